// File: rtl/lcd_hex_panel.sv
// lcd_hex_panel: renders NUM_FIELDS hex values onto a 2x16 character LCD.
// A launch snapshots the inputs, emits one ASCII digit per cycle into a
// work buffer preloaded with FILL_CHAR, then copies the whole buffer to the
// row outputs in a single commit cycle so partial results are never shown.
// Optional build macro: LCD_HEX_ZERO_BLANK_EN replaces leading zero digits
// of each field with spaces (the last digit of a field is always printed).
module lcd_hex_panel #(
    parameter int                      NUM_FIELDS     = 4,
    parameter int                      MAX_DIGITS     = 4,
    parameter logic [5*NUM_FIELDS-1:0] FIELD_POS      = {5'd24, 5'd16, 5'd8, 5'd0},
    parameter logic [3*NUM_FIELDS-1:0] FIELD_LEN      = {3'd4, 3'd2, 3'd2, 3'd2},
    parameter logic [7:0]              FILL_CHAR      = 8'h3F,
    parameter int                      REFRESH_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NUM_FIELDS*MAX_DIGITS*4-1:0] vals,
    output logic                               busy,
    output logic                               done,
    output logic [127:0]                       row_A,
    output logic [127:0]                       row_B
);

    // ---------------------------------------------------------------
    // Elaboration-time digit schedule: step k of the conversion maps to
    // a fixed (field, digit) pair, so zero-length fields cost no cycles.
    // ---------------------------------------------------------------
    function automatic int len_of(input int f);
        return int'(FIELD_LEN[3*f +: 3]);
    endfunction

    function automatic int total_digits();
        int acc;
        acc = 0;
        for (int f = 0; f < NUM_FIELDS; f++) acc += len_of(f);
        return acc;
    endfunction

    function automatic int step_field(input int k);
        int acc;
        int r;
        acc = 0;
        r   = 0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (k >= acc && k < acc + len_of(f)) r = f;
            acc += len_of(f);
        end
        return r;
    endfunction

    function automatic int step_digit(input int k);
        int acc;
        int r;
        acc = 0;
        r   = 0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (k >= acc && k < acc + len_of(f)) r = k - acc;
            acc += len_of(f);
        end
        return r;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    localparam int D  = total_digits();
    localparam int DS = (D > 0) ? D : 1;
    localparam int KW = (DS > 1) ? $clog2(DS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t  state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic    pending_q, pending_d;
    logic    launch;
    logic    tick;
    logic    done_q;

    logic [NUM_FIELDS*MAX_DIGITS*4-1:0] vals_q;
    logic [7:0] work_q [32];
    logic [7:0] disp_q [32];

    logic [3:0] step_nib [DS];
    logic [5:0] step_chr [DS];
`ifdef LCD_HEX_ZERO_BLANK_EN
    logic [DS-1:0] step_first;
    logic [DS-1:0] step_last;
`endif

    for (genvar gi = 0; gi < DS; gi++) begin : g_step
        localparam int F   = step_field(gi);
        localparam int DG  = step_digit(gi);
        localparam int LEN = len_of(F);
        localparam int POS = int'(FIELD_POS[5*F +: 5]);
        localparam int NIB = (LEN > 0) ? (LEN - 1 - DG) : 0;
        localparam int OFF = F*4*MAX_DIGITS + 4*NIB;
        assign step_nib[gi] = vals_q[OFF +: 4];
        assign step_chr[gi] = 6'(POS + DG);
`ifdef LCD_HEX_ZERO_BLANK_EN
        assign step_first[gi] = (DG == 0);
        assign step_last[gi]  = (DG == LEN - 1);
`endif
    end

    // Nibbles beyond a field's length are snapshotted but never displayed.
    logic unused_vals;
    assign unused_vals = ^vals_q;

    // ---------------------------------------------------------------
    // Auto-refresh: counts idle cycles only, cleared by every launch.
    // ---------------------------------------------------------------
    if (REFRESH_CYCLES > 0) begin : g_refresh
        logic [31:0] cnt_q;
        // Idle-cycle counter for the periodic refresh tick
        always_ff @(posedge clk) begin
            if (reset || launch) cnt_q <= '0;
            else if (state_q == IDLE) cnt_q <= cnt_q + 32'd1;
        end
        assign tick = (state_q == IDLE) && (cnt_q == 32'(REFRESH_CYCLES - 1));
    end else begin : g_no_refresh
        assign tick = 1'b0;
    end

    // FSM next state, launch decision and sticky pending request
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pending_d = pending_q;
        launch    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || pending_q || tick) begin
                    launch    = 1'b1;
                    pending_d = 1'b0;
                    k_d       = '0;
                    state_d   = (D == 0) ? COMMIT : CONV;
                end
            end
            CONV: begin
                if (start) pending_d = 1'b1;
                if (k_q == KW'(D - 1)) state_d = COMMIT;
                else                   k_d     = k_q + 1'b1;
            end
            COMMIT: begin
                if (start) pending_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, step counter and pending flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pending_q <= pending_d;
        end
    end

    // Current digit: its nibble, target character and ASCII code
    logic [3:0] nib;
    logic [5:0] chr;
    logic [7:0] code;
    assign nib = step_nib[k_q];
    assign chr = step_chr[k_q];

`ifdef LCD_HEX_ZERO_BLANK_EN
    logic lead_q, lead_d, lead_now;
    // A digit is blanked while every digit before it in the field was zero
    always_comb begin
        lead_now = step_first[k_q] | lead_q;
        lead_d   = lead_now & (nib == 4'h0);
        code     = hex_ascii(nib);
        if (lead_d && !step_last[k_q]) code = 8'h20;
    end

    // Leading-zero tracker across the digits of one field
    always_ff @(posedge clk) begin
        if (reset)                lead_q <= 1'b0;
        else if (state_q == CONV) lead_q <= lead_d;
    end
`else
    assign code = hex_ascii(nib);
`endif

    // Input snapshot on the launch edge
    always_ff @(posedge clk) begin
        if (launch) vals_q <= vals;
    end

    // Work buffer: fill on launch, one digit per conversion cycle;
    // characters past index 31 are dropped (chr[5] set)
    always_ff @(posedge clk) begin
        if (launch) begin
            for (int c = 0; c < 32; c++) work_q[c] <= FILL_CHAR;
        end else if (state_q == CONV && !chr[5]) begin
            work_q[chr[4:0]] <= code;
        end
    end

    // Display registers and done pulse, updated only at commit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 32; c++) disp_q[c] <= FILL_CHAR;
            done_q <= 1'b0;
        end else begin
            if (state_q == COMMIT) begin
                for (int c = 0; c < 32; c++) disp_q[c] <= work_q[c];
            end
            done_q <= (state_q == COMMIT);
        end
    end

    assign busy = (state_q != IDLE) | done_q;
    assign done = done_q;

    for (genvar gi = 0; gi < 16; gi++) begin : g_row
        assign row_A[127-8*gi -: 8] = disp_q[gi];
        assign row_B[127-8*gi -: 8] = disp_q[16+gi];
    end

endmodule

// File: doc/lcd_hex_panel.md
LCD_HEX_PANEL -- requirements
Module: lcd_hex_panel

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 4, number of hex fields shown.
REQ-002 SHALL have parameter MAX_DIGITS, default 4, maximum hex digits per field (1..8).
REQ-003 SHALL have parameter FIELD_POS, default {5'd24,5'd16,5'd8,5'd0}, start character of field i at bits [5*i+:5]; characters 0..15 are row_A and 16..31 are row_B.
REQ-004 SHALL have parameter FIELD_LEN, default {3'd4,3'd2,3'd2,3'd2}, digit count of field i at bits [3*i+:3]; 0 disables the field.
REQ-005 SHALL have parameter FILL_CHAR, default 8'h3F ('?'), used for every character not covered by a field.
REQ-006 SHALL have parameter REFRESH_CYCLES, default 0, auto-refresh period in cycles; 0 disables auto-refresh.
REQ-007 clk  input  1  single clock; all logic on posedge clk.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  request one conversion, level sampled each cycle.
REQ-010 vals  input  NUM_FIELDS*MAX_DIGITS*4  field i value at [i*4*MAX_DIGITS +: 4*MAX_DIGITS]; only the low FIELD_LEN nibbles are shown.
REQ-011 busy  output  1  high from launch until the commit cycle, inclusive.
REQ-012 done  output  1  one-cycle pulse on the commit cycle.
REQ-013 row_A  output  128  LCD line 1; character c occupies bits [127-8c -: 8].
REQ-014 row_B  output  128  LCD line 2; same layout for characters 16..31.

Function
REQ-015 SHALL implement FSM IDLE -> CONV -> COMMIT -> IDLE.
REQ-016 In IDLE, launch occurs when start, a pending request, or an auto-refresh tick is present; the launch edge snapshots vals and enters CONV.
REQ-017 CONV SHALL emit exactly one digit per cycle:
- fields in ascending index order, skipping len-0 fields in zero cycles;
- within a field, MSB digit first, written to work-buffer character FIELD_POS+d.
REQ-018 Digit encoding: 0-9 -> 8'h30-8'h39; 10-15 -> 8'h41-8'h46.
REQ-019 The work buffer SHALL be preloaded with FILL_CHAR at every launch.
REQ-020 Characters whose index exceeds 31 SHALL be dropped, with no wrap-around; they still consume their digit cycle.
REQ-021 Overlapping fields: the higher field index SHALL win.
REQ-022 COMMIT SHALL copy the work buffer to row_A/row_B in one cycle and assert done for that cycle only.
REQ-023 Latency: with launch edge t and D = sum of FIELD_LEN, rows update and done=1 at edge t+D+1; the next launch is possible at edge t+D+2.
REQ-024 start while busy SHALL set a single sticky pending flag (multiple requests collapse to one); pending triggers a launch on the first IDLE cycle and clears at launch.
REQ-025 Auto-refresh counter SHALL count only in IDLE, tick at REFRESH_CYCLES-1, and reset to 0 on any launch.
REQ-026 row_A/row_B SHALL change only at COMMIT, so the display never shows a partial conversion.
REQ-027 If D=0, the block SHALL go launch -> COMMIT directly, writing all FILL_CHAR.

Reset
REQ-028 Reset SHALL set row_A = row_B = 16 x FILL_CHAR, busy=0, done=0, pending=0, refresh counter=0, and state IDLE.
REQ-029 Reset during CONV or COMMIT SHALL abort the conversion with no done pulse and the rows restored to fill.

Configuration
REQ-030 Macro LCD_HEX_ZERO_BLANK_EN, when defined, SHALL replace each leading zero digit of a field with 8'h20 (space); the field's last digit is always printed. Timing is unchanged.
REQ-031 Without LCD_HEX_ZERO_BLANK_EN, all digits SHALL be printed, including leading zeros.

Verification
REQ-032 Apply reset, no start -> both rows all 8'h3F, busy=0, done never asserted.
REQ-033 Defaults; vals f0=8'h3C, f1=8'h07, f2=8'hFF, f3=16'h1234; start at edge t -> done at edge t+11; row_A chars 0-1 "3C" and 8-9 "07"; row_B chars 0-1 "FF" and 8-11 "1234"; all other chars '?'.
REQ-034 start asserted 3 times during busy, then f3 changed to 16'hBEEF -> exactly one extra conversion, launched the cycle after done, shows "BEEF".
REQ-035 FIELD_POS f3=30, len 4, value 16'hABCD -> chars 30-31 "AB", char 0 unaffected by f3, done still at t+11.
REQ-036 Reset asserted at cycle t+5 of a conversion -> next cycle busy=0, rows all '?', no done pulse.
REQ-037 With LCD_HEX_ZERO_BLANK_EN: f3=16'h0040 -> "  40", f3=0 -> "   0"; without the macro f3=16'h0040 -> "0040".
